// File: rtl/sprite_index_fetch_pkg.sv
// Shared types and constants for the sprite index fetch stage.
package sprite_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    ATTACK = 2'd2
  } anim_state_t;

  // Per-direction sub-frame numbering: walk 1/2, then sword 1-4.
  localparam logic [2:0] SUB_WALK0     = 3'd0;
  localparam logic [2:0] SUB_WALK1     = 3'd1;
  localparam logic [2:0] SUB_ATK_FIRST = 3'd2;
  localparam logic [2:0] SUB_ATK_LAST  = 3'd5;

  localparam int unsigned FRAMES_PER_DIR = 6;

  // Visible raster limits; pixels at or beyond these are never sprite hits.
  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;

  // Global frame number: dir * FRAMES_PER_DIR + sub.
  function automatic logic [4:0] frame_index(input dir_t d, input logic [2:0] sub);
    return 5'(d) * 5'(FRAMES_PER_DIR) + 5'(sub);
  endfunction

endpackage

// File: rtl/sprite_index_fetch_anim_fsm.sv
// Animation state machine: picks the sub-frame and direction, advancing
// only on frame_tick so a displayed frame never changes mid-screen.
module sprite_anim_fsm
  import sprite_pkg::*;
#(
  parameter int unsigned ANIM_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       moving,
  input  logic       attack,
  input  logic [1:0] dir,
  output logic [4:0] frame_id,
  output logic       attack_busy
);

  localparam int unsigned STEP_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ANIM_DIV - 1);

  anim_state_t       state, state_nx;
  logic [STEP_W-1:0] step, step_nx;
  logic [2:0]        sub, sub_nx;
  dir_t              dir_q, dir_nx;
  logic              attack_d;
  logic              attack_req, attack_req_nx;
  logic              attack_rise, req_now;

  // State, step counter, latched direction and attack request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step       <= '0;
      sub        <= SUB_WALK0;
      dir_q      <= DIR_UP;
      attack_d   <= 1'b0;
      attack_req <= 1'b0;
    end else begin
      state      <= state_nx;
      step       <= step_nx;
      sub        <= sub_nx;
      dir_q      <= dir_nx;
      attack_d   <= attack;
      attack_req <= attack_req_nx;
    end
  end

  // Next-state logic; a rise coinciding with a tick is folded into req_now
  // so the request is consumed on that same tick.
  always_comb begin
    attack_rise   = attack & ~attack_d;
    req_now       = attack_req | attack_rise;
    state_nx      = state;
    step_nx       = step;
    sub_nx        = sub;
    dir_nx        = dir_q;
    attack_req_nx = req_now;
    if (state == ATTACK) attack_req_nx = 1'b0;
    if (frame_tick) begin
      case (state)
        IDLE: begin
          dir_nx        = dir_t'(dir);
          attack_req_nx = 1'b0;
          if (req_now) begin
            state_nx = ATTACK;
            sub_nx   = SUB_ATK_FIRST;
            step_nx  = '0;
          end else if (moving) begin
            state_nx = WALK;
            sub_nx   = SUB_WALK0;
            step_nx  = '0;
          end
        end
        WALK: begin
          dir_nx        = dir_t'(dir);
          attack_req_nx = 1'b0;
          if (req_now) begin
            state_nx = ATTACK;
            sub_nx   = SUB_ATK_FIRST;
            step_nx  = '0;
          end else if (!moving) begin
            state_nx = IDLE;
            sub_nx   = SUB_WALK0;
            step_nx  = '0;
          end else if (step == STEP_LAST) begin
            step_nx = '0;
            sub_nx  = (sub == SUB_WALK0) ? SUB_WALK1 : SUB_WALK0;
          end else begin
            step_nx = step + 1'b1;
          end
        end
        ATTACK: begin
          if (step == STEP_LAST) begin
            step_nx = '0;
            if (sub == SUB_ATK_LAST) begin
              state_nx = moving ? WALK : IDLE;
              sub_nx   = SUB_WALK0;
            end else begin
              sub_nx = sub + 3'd1;
            end
          end else begin
            step_nx = step + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          sub_nx   = SUB_WALK0;
          step_nx  = '0;
        end
      endcase
    end
  end

  assign frame_id    = frame_index(dir_q, sub);
  assign attack_busy = (state == ATTACK);

endmodule

// File: rtl/sprite_index_fetch.sv
// Per-pixel sprite stage: box test and ROM addressing, then a fixed
// 2-edge pipeline aligning flags with the synchronous ROM output.
module sprite_index_fetch
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W      = 32,
  parameter int unsigned SPR_H      = 32,
  parameter int unsigned ANIM_DIV   = 8,
  parameter logic [3:0]  TRANSP_IDX = 4'h0,
  parameter int unsigned ADDR_W     = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank_n,
  input  logic [9:0]        SpriteX,
  input  logic [9:0]        SpriteY,
  input  logic [1:0]        dir,
  input  logic              moving,
  input  logic              attack,
  input  logic              frame_tick,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic              pix_valid,
  output logic              sprite_hit,
  output logic [3:0]        pal_index,
  output logic [4:0]        frame_id,
  output logic              attack_busy
);

  localparam logic signed [10:0] W_S = 11'(SPR_W);
  localparam logic signed [10:0] H_S = 11'(SPR_H);

  logic [4:0]         anim_fid;
  logic signed [10:0] rel_x, rel_y;
  logic               in_box;
  logic [ADDR_W-1:0]  addr_calc;
  logic               in_box1, blank1, in_box2, blank2;
  logic [4:0]         fid1, fid2;
  logic               hit_now;

  sprite_anim_fsm #(
    .ANIM_DIV(ANIM_DIV)
  ) u_anim (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .frame_tick (frame_tick),
    .moving     (moving),
    .attack     (attack),
    .dir        (dir),
    .frame_id   (anim_fid),
    .attack_busy(attack_busy)
  );

  // Box test in 11-bit signed so boxes near the right/bottom edge never wrap.
  always_comb begin
    rel_x     = $signed({1'b0, DrawX}) - $signed({1'b0, SpriteX});
    rel_y     = $signed({1'b0, DrawY}) - $signed({1'b0, SpriteY});
    in_box    = !rel_x[10] && !rel_y[10] && (rel_x < W_S) && (rel_y < H_S) &&
                (DrawX < H_ACTIVE) && (DrawY < V_ACTIVE);
    addr_calc = '0;
    if (in_box)
      addr_calc = ADDR_W'(anim_fid) * ADDR_W'(SPR_W * SPR_H) +
                  ADDR_W'(rel_y) * ADDR_W'(SPR_W) + ADDR_W'(rel_x);
  end

  // Stage 1: register ROM address and the per-pixel side information.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      in_box1  <= 1'b0;
      blank1   <= 1'b0;
      fid1     <= '0;
    end else begin
      rom_addr <= addr_calc;
      in_box1  <= in_box;
      blank1   <= blank_n;
      fid1     <= anim_fid;
    end
  end

  // Stage 2: delay side information by the ROM read latency.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_box2 <= 1'b0;
      blank2  <= 1'b0;
      fid2    <= '0;
    end else begin
      in_box2 <= in_box1;
      blank2  <= blank1;
      fid2    <= fid1;
    end
  end

  assign hit_now = in_box2 && (rom_data != TRANSP_IDX);

  // Output stage: combine the ROM index with the aligned flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_valid  <= 1'b0;
      sprite_hit <= 1'b0;
      pal_index  <= '0;
      frame_id   <= '0;
    end else begin
      pix_valid  <= blank2;
      sprite_hit <= hit_now;
      pal_index  <= hit_now ? rom_data : '0;
      frame_id   <= fid2;
    end
  end

endmodule

// File: tb/tb_sprite_index_fetch.sv
// Scoreboard bench for sprite_index_fetch with a behavioural sync ROM
// whose content is rom_addr[3:0] ^ 4'hA.
module tb_sprite_index_fetch;

  localparam int unsigned ADDR_W = 15;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic [9:0]        DrawX = '0, DrawY = '0, SpriteX = 10'd100, SpriteY = 10'd50;
  logic              blank_n = 1'b0;
  logic [1:0]        dir = 2'd0;
  logic              moving = 1'b0, attack = 1'b0, frame_tick = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data = '0;
  logic              pix_valid, sprite_hit, attack_busy;
  logic [3:0]        pal_index;
  logic [4:0]        frame_id;

  typedef struct {
    logic       hit;
    logic [3:0] pal;
    logic [4:0] fid;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  sprite_index_fetch #(
    .SPR_W(32), .SPR_H(32), .ANIM_DIV(8), .TRANSP_IDX(4'h0), .ADDR_W(ADDR_W)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank_n(blank_n),
    .SpriteX(SpriteX), .SpriteY(SpriteY), .dir(dir), .moving(moving), .attack(attack),
    .frame_tick(frame_tick), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .sprite_hit(sprite_hit), .pal_index(pal_index),
    .frame_id(frame_id), .attack_busy(attack_busy)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM: data for an address appears one edge later.
  always @(posedge Clk) rom_data <= rom_addr[3:0] ^ 4'hA;

  // Monitor: every valid output pixel must match the oldest expected entry.
  always @(negedge Clk) begin
    if (Reset_n && pix_valid) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pixel: pix_valid=1 got hit=%0b pal=%h fid=%0d, need no output",
                 sprite_hit, pal_index, frame_id);
      end else begin
        mon_e = sbq.pop_front();
        if (sprite_hit !== mon_e.hit || pal_index !== mon_e.pal || frame_id !== mon_e.fid) begin
          bad++;
          $display("FAIL pixel: got hit=%0b pal=%h fid=%0d need hit=%0b pal=%h fid=%0d",
                   sprite_hit, pal_index, frame_id, mon_e.hit, mon_e.pal, mon_e.fid);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d need %0d", nm, got, want);
    end
  endtask

  // Drive one pixel for one clock; check its ROM address at the next negedge.
  task automatic pix(input int x, input int y, input logic bl, input int want_addr,
                     input logic hit, input logic [3:0] pal, input logic [4:0] fid);
    DrawX   = 10'(x);
    DrawY   = 10'(y);
    blank_n = bl;
    if (bl) sbq.push_back('{hit, pal, fid});
    @(negedge Clk);
    check("rom_addr", 32'(rom_addr), 32'(want_addr));
    blank_n = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  // Off-sprite pixel used to observe the current frame_id through the pipeline.
  task automatic probe(input logic [4:0] fid, input logic busy, input string nm);
    check(nm, 32'(attack_busy), 32'(busy));
    pix(0, 0, 1'b1, 0, 1'b0, 4'h0, fid);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, need finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int sub;
    repeat (2) @(negedge Clk);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_frame_id", 32'(frame_id), 0);
    check("rst_attack_busy", 32'(attack_busy), 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Frame 0, relX=5 relY=2 -> addr 69, ROM 0x5^0xA = 0xF.
    repeat (3) pix(105, 52, 1'b1, 69, 1'b1, 4'hF, 5'd0);

    // Asynchronous reset mid-line with valid pixels in flight.
    #2 Reset_n = 1'b0;
    #1;
    check("rst_async_pix_valid", 32'(pix_valid), 0);
    check("rst_async_hit", 32'(sprite_hit), 0);
    check("rst_async_pal", 32'(pal_index), 0);
    check("rst_async_rom_addr", 32'(rom_addr), 0);
    sbq.delete();
    DrawX = 10'd105; DrawY = 10'd52; blank_n = 1'b1;
    @(negedge Clk);
    #2 Reset_n = 1'b1;
    sbq.push_back('{1'b1, 4'hF, 5'd0});
    @(posedge Clk); #1 blank_n = 1'b0;
    check("post_rst_edge1_valid", 32'(pix_valid), 0);
    @(posedge Clk); #1;
    check("post_rst_edge2_valid", 32'(pix_valid), 0);
    @(posedge Clk); #1;
    check("post_rst_edge3_valid", 32'(pix_valid), 1);
    @(negedge Clk);

    // IDLE, latch dir=down -> frame 6.
    dir = 2'd1;
    tick();
    probe(5'd6, 1'b0, "idle_busy");
    pix(100, 50, 1'b1, 6144, 1'b1, 4'hA, 5'd6);
    pix(131, 81, 1'b1, 7167, 1'b1, 4'h5, 5'd6);
    pix(132, 81, 1'b1, 0,    1'b0, 4'h0, 5'd6);
    pix(110, 50, 1'b1, 6154, 1'b0, 4'h0, 5'd6);
    pix(99,  50, 1'b1, 0,    1'b0, 4'h0, 5'd6);
    pix(100, 49, 1'b1, 0,    1'b0, 4'h0, 5'd6);
    pix(105, 52, 1'b1, 6213, 1'b1, 4'hF, 5'd6);
    pix(100, 50, 1'b0, 6144, 1'b0, 4'h0, 5'd6);
    SpriteX = 10'd620;
    pix(639, 50, 1'b1, 6163, 1'b1, 4'h9, 5'd6);
    pix(640, 50, 1'b1, 0,    1'b0, 4'h0, 5'd6);
    SpriteX = 10'd100; SpriteY = 10'd470;
    pix(100, 479, 1'b1, 6432, 1'b1, 4'hA, 5'd6);
    pix(100, 480, 1'b1, 0,    1'b0, 4'h0, 5'd6);
    SpriteY = 10'd50;

    // Walking: sub 0,1,0,1, each held for 8 ticks.
    moving = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      tick();
      sub = ((n - 1) / 8) % 2;
      probe(5'(6 + sub), 1'b0, "walk_busy");
    end

    // Attack pulse, stop moving: sub 2..5 over 32 ticks, then IDLE.
    moving = 1'b0;
    attack = 1'b1;
    @(negedge Clk);
    attack = 1'b0;
    for (int a = 1; a <= 34; a++) begin
      if (a == 3) dir = 2'd3;
      if (a == 5) begin
        attack = 1'b1;
        @(negedge Clk);
        attack = 1'b0;
      end
      tick();
      if (a <= 32) probe(5'(6 + 2 + (a - 1) / 8), 1'b1, "attack_busy");
      else if (a == 33) probe(5'd6, 1'b0, "attack_end_busy");
      else probe(5'd18, 1'b0, "idle_after_attack_busy");
    end

    // Rise of attack on the same cycle as a tick is consumed by that tick.
    attack = 1'b1; frame_tick = 1'b1;
    @(negedge Clk);
    attack = 1'b0; frame_tick = 1'b0;
    probe(5'd20, 1'b1, "rise_with_tick_busy");

    repeat (8) @(negedge Clk);
    check("scoreboard_drained", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
